// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared types and width defaults for the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
// ============================================================================
// Module  : mem_watchdog
// Brief   : Saturating busy-cycle counter with a sticky timeout flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counter parks at LIMIT; every further enabled cycle there keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable) begin
            if (wd_cnt == LIMIT) begin
                err_timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin sharing of one memory port between fetch (I) and Mem (D).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_en,
    input  logic              d_wren,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              owner_d,
    output logic              err_timeout,
    output logic              err_spurious
);

    arb_state_t state;
    req_id_t    last_grant;
    logic       grant_any;
    logic       grant_d;
    logic       wd_enable;

    assign grant_any = (state == IDLE) && (i_en || d_en);
    // On a tie D wins unless it was the last one served.
    assign grant_d   = d_en && (!i_en || (last_grant == REQ_I));
    assign wd_enable = (state == BUSY) && !mem_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= REQ_I;
            i_rdata      <= '0;
            i_done       <= 1'b0;
            d_rdata      <= '0;
            d_done       <= 1'b0;
            mem_en       <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            owner_d      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (mem_done && (state != BUSY)) begin
                err_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if (grant_d) begin
                            mem_wren   <= d_wren;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            owner_d    <= 1'b1;
                            last_grant <= REQ_D;
                        end else begin
                            mem_wren   <= 1'b0;
                            mem_addr   <= i_addr;
                            mem_wdata  <= '0;
                            owner_d    <= 1'b0;
                            last_grant <= REQ_I;
                        end
                        mem_en <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        mem_en <= 1'b0;
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (grant_any),
        .enable      (wd_enable),
        .err_timeout (err_timeout)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed plus randomized bench with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_en = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_en = 1'b0;
    logic          d_wren = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_en;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          owner_d;
    logic          err_timeout;
    logic          err_spurious;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_en(d_en), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .owner_d(owner_d), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic          e_mem_en = 0, e_mem_wren = 0, e_i_done = 0, e_d_done = 0;
    logic          e_owner_d = 0, e_err_to = 0, e_err_sp = 0;
    logic [AW-1:0] e_mem_addr = '0;
    logic [DW-1:0] e_mem_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;
    bit            m_busy = 0, m_resp = 0, m_last_d = 0, m_take_d = 0;
    int            m_busy_cycles = 0;
    int            cyc = 0;

    always @(posedge clk or negedge reset_n) begin
        cyc++;
        if (!reset_n) begin
            {e_mem_en, e_mem_wren, e_i_done, e_d_done, e_owner_d, e_err_to, e_err_sp} = '0;
            e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
            m_busy = 0; m_resp = 0; m_last_d = 0; m_busy_cycles = 0;
        end else begin
            if (mem_done && !m_busy) e_err_sp = 1'b1;
            if (m_resp) begin
                m_resp = 0; e_i_done = 0; e_d_done = 0;
            end else if (m_busy) begin
                if (mem_done) begin
                    m_busy = 0; m_resp = 1; e_mem_en = 0;
                    if (e_owner_d) begin e_d_rdata = mem_rdata; e_d_done = 1; end
                    else begin e_i_rdata = mem_rdata; e_i_done = 1; end
                end else begin
                    m_busy_cycles++;
                    if (m_busy_cycles >= TO) e_err_to = 1'b1;
                end
            end else if (i_en || d_en) begin
                m_take_d = d_en && !(i_en && m_last_d);
                m_last_d = m_take_d;
                e_owner_d = m_take_d;
                e_mem_addr  = m_take_d ? d_addr : i_addr;
                e_mem_wren  = m_take_d ? d_wren : 1'b0;
                e_mem_wdata = m_take_d ? d_wdata : '0;
                e_mem_en = 1; m_busy = 1; m_busy_cycles = 0;
            end
        end
    end

    // ---------------- per-cycle compare and grant log ----------------
    bit cmp_on = 0;
    bit prev_mem_en = 0;
    int dut_who[$];
    int dut_at[$];

    always @(negedge clk) begin
        if (cmp_on && reset_n) begin
            check("mem_en", mem_en, e_mem_en);
            check("mem_wren", mem_wren, e_mem_wren);
            check("mem_addr", mem_addr, e_mem_addr);
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("i_rdata", i_rdata, e_i_rdata);
            check("i_done", i_done, e_i_done);
            check("d_rdata", d_rdata, e_d_rdata);
            check("d_done", d_done, e_d_done);
            check("owner_d", owner_d, e_owner_d);
            check("err_timeout", err_timeout, e_err_to);
            check("err_spurious", err_spurious, e_err_sp);
        end
        if (reset_n) begin
            if (mem_en && !prev_mem_en) begin
                dut_who.push_back(int'(owner_d));
                dut_at.push_back(cyc);
            end
            prev_mem_en = mem_en;
        end else begin
            prev_mem_en = 0;
        end
    end

    // ---------------- memory responder ----------------
    int            mem_mode = 0;      // 0: only injected pulses, 1: fixed latency, 2: random
    int            fix_lat = 0;
    logic [DW-1:0] fix_rdata = '0;
    int            spur_cnt = 0;
    int            spur_seen = 0;
    bit            answered = 0, counting = 0;
    int            lat = 0;

    always @(negedge clk) begin
        if (mem_mode == 0) begin
            if (spur_cnt != spur_seen) begin
                mem_done = 1'b1; spur_seen = spur_cnt;
            end else begin
                mem_done = 1'b0;
            end
        end else begin
            if (mem_done) begin
                mem_done = 1'b0;
            end else if (mem_en && !answered) begin
                if (!counting) begin
                    lat = (mem_mode == 1) ? fix_lat : int'($urandom_range(0, 3));
                    counting = 1;
                end
                if (lat == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = (mem_mode == 1) ? fix_rdata : {$urandom, $urandom};
                    answered = 1; counting = 0;
                end else begin
                    lat--;
                end
            end
            if (!mem_en) answered = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input bit want_d, input string name, output int n);
        n = 0;
        while (((want_d ? d_done : i_done) !== 1'b1) && (n < 50)) begin
            tick(); n++;
        end
        check(name, want_d ? d_done : i_done, 1'b1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_wren"}, mem_wren, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_i_rdata"}, i_rdata, 0);
        check({tag, "_i_done"}, i_done, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_d_done"}, d_done, 0);
        check({tag, "_owner_d"}, owner_d, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_err_spurious"}, err_spurious, 0);
    endtask

    task automatic rand_step();
        if (i_en && i_done) begin
            i_en = 1'($urandom_range(0, 1));
            i_addr = {$urandom, $urandom};
        end else if (!i_en && $urandom_range(0, 2) == 0) begin
            i_en = 1'b1; i_addr = {$urandom, $urandom};
        end
        if ((d_en && d_done) || (!d_en && $urandom_range(0, 2) == 0)) begin
            d_en    = (d_en && d_done) ? 1'($urandom_range(0, 1)) : 1'b1;
            d_wren  = 1'($urandom_range(0, 1));
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        tick(); tick();
        reset_check("reset");
        reset_n = 1'b1;
        cmp_on = 1;

        // D read alone, memory answers 3 cycles after mem_en
        mem_mode = 1; fix_lat = 2; fix_rdata = 64'hDEAD_BEEF;
        d_en = 1; d_wren = 0; d_addr = 64'h1000;
        tick();
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_addr", mem_addr, 64'h1000);
        check("t1_mem_wren", mem_wren, 0);
        wait_done(1, "t1_d_done", n);
        check("t1_latency", n, 3);
        check("t1_d_rdata", d_rdata, 64'hDEAD_BEEF);
        check("t1_i_done", i_done, 0);
        d_en = 0;
        tick();
        check("t1_d_done_one_cycle", d_done, 0);
        tick();

        // Simultaneous requests after reset: D first, I two cycles after d_done
        reset_n = 0; tick(); reset_n = 1;
        fix_lat = 0; fix_rdata = 64'h1234_5678_9ABC_DEF0;
        i_en = 1; i_addr = 64'h400;
        d_en = 1; d_wren = 1; d_addr = 64'h2000; d_wdata = 64'h55;
        tick();
        check("t2_owner_d", owner_d, 1);
        check("t2_mem_wren", mem_wren, 1);
        check("t2_mem_wdata", mem_wdata, 64'h55);
        check("t2_mem_addr", mem_addr, 64'h2000);
        wait_done(1, "t2_d_done", n);
        d_en = 0; d_wren = 0;
        tick();
        check("t2_resp_gap", mem_en, 0);
        tick();
        check("t2_i_granted", mem_en, 1);
        check("t2_i_addr", mem_addr, 64'h400);
        check("t2_i_owner", owner_d, 0);
        check("t2_i_wren", mem_wren, 0);
        wait_done(0, "t2_i_done", n);
        check("t2_i_rdata", i_rdata, 64'h1234_5678_9ABC_DEF0);
        i_en = 0;
        tick(); tick();

        // Both held: six alternating grants, one every three cycles
        dut_who.delete(); dut_at.delete();
        i_en = 1; i_addr = 64'h800; d_en = 1; d_wren = 0; d_addr = 64'h3000;
        n = 0;
        while (dut_who.size() < 6 && n < 100) begin
            tick(); n++;
            if (i_done) i_addr += 8;
            if (d_done) d_addr += 8;
        end
        i_en = 0; d_en = 0;
        check("t3_grant_count", dut_who.size(), 6);
        for (int k = 0; k < 6 && k < dut_who.size(); k++)
            check($sformatf("t3_grant%0d_owner", k), dut_who[k], (k % 2 == 0) ? 1 : 0);
        for (int k = 0; k + 1 < 6 && k + 1 < dut_at.size(); k++)
            check($sformatf("t3_gap%0d", k), dut_at[k+1] - dut_at[k], 3);
        repeat (4) tick();

        // Minimum latency: no re-grant in RESP although i_en stays high
        i_en = 1; i_addr = 64'h400;
        tick();
        check("t4_mem_en_N", mem_en, 1);
        tick();
        check("t4_i_done_N1", i_done, 1);
        check("t4_mem_en_N1", mem_en, 0);
        tick();
        check("t4_no_regrant_N2", mem_en, 0);
        check("t4_i_done_N2", i_done, 0);
        tick();
        check("t4_regrant_N3", mem_en, 1);
        i_en = 0;
        tick();
        check("t4_dropped_still_done", i_done, 1);
        repeat (3) tick();

        // Randomized traffic
        mem_mode = 2;
        repeat (1500) begin
            tick(); rand_step();
        end
        n = 0;
        while ((i_en || d_en || mem_en) && n < 200) begin
            tick(); n++;
            if (i_done) i_en = 0;
            if (d_done) d_en = 0;
        end
        check("rand_drained", {i_en, d_en, mem_en}, 0);
        repeat (3) tick();
        check("rand_no_err_to", err_timeout, 0);
        check("rand_no_err_sp", err_spurious, 0);

        // Spurious mem_done while idle
        mem_mode = 0;
        tick();
        spur_cnt++;
        repeat (3) tick();
        check("t5_err_spurious", err_spurious, 1);
        check("t5_i_done", i_done, 0);
        check("t5_d_done", d_done, 0);

        // Watchdog: D granted, memory never answers
        d_en = 1; d_wren = 0; d_addr = 64'h5000;
        tick();
        check("t6_mem_en", mem_en, 1);
        repeat (15) tick();
        check("t6_err_before", err_timeout, 0);
        tick();
        check("t6_err_at_16", err_timeout, 1);
        repeat (3) tick();
        check("t6_err_sticky", err_timeout, 1);
        check("t6_mem_en_held", mem_en, 1);
        check("t6_no_done", d_done, 0);

        // Asynchronous reset in the middle of BUSY
        #2 reset_n = 0;
        #1 reset_check("t6_rst");
        d_en = 0;
        tick();
        reset_n = 1;
        repeat (2) tick();
        check("t6_after_rst_idle", mem_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
